// File: rtl/regfile_wr_arbiter.sv
// Round-robin owner of the 8x16 register file write port, with registered ld_reg/dr/d_in.
// Define REGFILE_ARB_CLEAR_EN to zero every register in a sweep after reset release.
//
// state    | meaning
// ST_CLEAR | post-reset sweep: one register zeroed per cycle, requests held off
// ST_ARB   | round-robin arbitration among requesters (terminal until reset)

module regfile_wr_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 3,
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] req_dr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic              ld_reg,
  output logic [AW-1:0]     dr,
  output logic [DW-1:0]     d_in,
  output logic              busy,
  output logic              clear_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] RR_INIT = PW'(NREQ - 1);

  if (NREG != (1 << AW)) begin : g_bad_nreg
    $error("regfile_wr_arbiter: NREG must equal 2**AW");
  end

  logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic            ld_reg_nxt;
  logic [AW-1:0]   dr_nxt;
  logic [DW-1:0]   d_in_nxt;
  logic            clear_done_nxt;

  logic [NREQ-1:0] eligible;
  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [NREQ-1:0] win_onehot;
  logic [AW-1:0]   win_dr;
  logic [DW-1:0]   win_data;
  int              win_dist;
  int              cand_dist;

  // A requester granted last cycle is masked: its req may still be stale this edge.
  always_comb begin
    eligible   = req & ~gnt;
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    win_dr     = '0;
    win_data   = '0;
    win_dist   = NREQ;
    cand_dist  = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand_dist = (i + 2 * NREQ - 1 - int'(rr_ptr)) % NREQ;
      if (eligible[i] && (cand_dist < win_dist)) begin
        win_found     = 1'b1;
        win_dist      = cand_dist;
        win_idx       = PW'(i);
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
        win_dr        = req_dr[i*AW +: AW];
        win_data      = req_data[i*DW +: DW];
      end
    end
  end

`ifdef REGFILE_ARB_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_ARB} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          busy_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= busy_nxt;
    end
  end

  // busy stays up through the cycle that commits the last swept register.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    busy_nxt       = busy;
    gnt_nxt        = '0;
    ld_reg_nxt     = 1'b0;
    dr_nxt         = dr;
    d_in_nxt       = d_in;
    rr_ptr_nxt     = rr_ptr;
    clear_done_nxt = clear_done;
    case (state)
      ST_CLEAR: begin
        ld_reg_nxt = 1'b1;
        dr_nxt     = cnt;
        d_in_nxt   = '0;
        cnt_nxt    = cnt + 1'b1;
        if (cnt == AW'(NREG - 1)) state_nxt = ST_ARB;
      end
      ST_ARB: begin
        clear_done_nxt = 1'b1;
        busy_nxt       = 1'b0;
        if (win_found) begin
          gnt_nxt    = win_onehot;
          ld_reg_nxt = 1'b1;
          dr_nxt     = win_dr;
          d_in_nxt   = win_data;
          rr_ptr_nxt = win_idx;
        end
      end
      default: state_nxt = ST_ARB;
    endcase
  end
`else
  assign busy = 1'b0;

  always_comb begin
    gnt_nxt        = '0;
    ld_reg_nxt     = 1'b0;
    dr_nxt         = dr;
    d_in_nxt       = d_in;
    rr_ptr_nxt     = rr_ptr;
    clear_done_nxt = 1'b1;
    if (win_found) begin
      gnt_nxt    = win_onehot;
      ld_reg_nxt = 1'b1;
      dr_nxt     = win_dr;
      d_in_nxt   = win_data;
      rr_ptr_nxt = win_idx;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt        <= '0;
      ld_reg     <= 1'b0;
      dr         <= '0;
      d_in       <= '0;
      rr_ptr     <= RR_INIT;
      clear_done <= 1'b0;
    end else begin
      gnt        <= gnt_nxt;
      ld_reg     <= ld_reg_nxt;
      dr         <= dr_nxt;
      d_in       <= d_in_nxt;
      rr_ptr     <= rr_ptr_nxt;
      clear_done <= clear_done_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Testbench for regfile_wr_arbiter: requesters modelled as pending-write records,
// grants predicted from the rotating-priority rule and compared every cycle.

module tb_regfile_wr_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 3;
  localparam int DW   = 16;
`ifdef REGFILE_ARB_CLEAR_EN
  localparam int INIT_EDGES = 8;
`else
  localparam int INIT_EDGES = 0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] req_dr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic              ld_reg;
  logic [AW-1:0]     dr;
  logic [DW-1:0]     d_in;
  logic              busy;
  logic              clear_done;

  regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .NREG(8)) dut (
    .clk(clk), .reset(reset), .req(req), .req_dr(req_dr), .req_data(req_data),
    .gnt(gnt), .ld_reg(ld_reg), .dr(dr), .d_in(d_in), .busy(busy),
    .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: pending write per requester, pointer, last grant, held outputs.
  logic [AW-1:0]   pd_dr   [NREQ];
  logic [DW-1:0]   pd_data [NREQ];
  int              m_rr;
  logic [NREQ-1:0] m_prev;
  logic [AW-1:0]   exp_dr;
  logic [DW-1:0]   exp_din;

  task automatic drive_bus();
    for (int i = 0; i < NREQ; i++) begin
      req_dr[i*AW +: AW]   = pd_dr[i];
      req_data[i*DW +: DW] = pd_data[i];
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] d, input logic [DW-1:0] v);
    pd_dr[i]   = d;
    pd_data[i] = v;
    req[2'(i)] = 1'b1;
    drive_bus();
  endtask

  // Reset (async), release, then check the init phase while 'hold' stays requested.
  task automatic do_reset(input logic [NREQ-1:0] hold, input string tag);
    logic [24:0] got, want;
    reset = 1'b1;
    req   = hold;
    drive_bus();
    #1;
    got  = {gnt, ld_reg, dr, d_in, clear_done, busy};
    want = {3'b000, 1'b0, 3'd0, 16'h0000, 1'b0, (INIT_EDGES > 0)};
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s_in_reset: got %h want %h", tag, got, want);
    end
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b0;
    m_rr    = NREQ - 1;
    m_prev  = '0;
    exp_dr  = '0;
    exp_din = '0;
    for (int e = 0; e < INIT_EDGES; e++) begin
      @(negedge clk);
      exp_dr = AW'(e);
      got  = {gnt, ld_reg, dr, d_in, clear_done, busy};
      want = {3'b000, 1'b1, exp_dr, 16'h0000, 1'b0, 1'b1};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL %s_sweep%0d: got %h want %h", tag, e, got, want);
      end
    end
  endtask

  // One arbitration cycle; called just after a negedge with inputs settled.
  task automatic step(input int p_rereq, input int p_raise, input logic [NREQ-1:0] allow,
                      input string tag);
    int w;
    int idx;
    logic [NREQ-1:0] exp_gnt;
    logic [24:0] got, want;
    w = -1;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (m_rr + off) % NREQ;
      if (w < 0 && req[2'(idx)] && !m_prev[2'(idx)]) w = idx;
    end
    exp_gnt = '0;
    if (w >= 0) begin
      exp_gnt = NREQ'(1 << w);
      exp_dr  = pd_dr[w];
      exp_din = pd_data[w];
      m_rr    = w;
    end
    m_prev = exp_gnt;
    @(negedge clk);
    got  = {gnt, ld_reg, dr, d_in, clear_done, busy};
    want = {exp_gnt, (w >= 0), exp_dr, exp_din, 1'b1, 1'b0};
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got gnt=%b ld=%b dr=%0d d_in=%h done=%b busy=%b want gnt=%b ld=%b dr=%0d d_in=%h done=1 busy=0",
               tag, gnt, ld_reg, dr, d_in, clear_done, busy, exp_gnt, (w >= 0), exp_dr, exp_din);
    end
    if (w >= 0) begin
      if ($urandom_range(99) < p_rereq) begin
        pd_dr[w]   = AW'($urandom);
        pd_data[w] = DW'($urandom);
      end else begin
        req[2'(w)] = 1'b0;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (allow[2'(i)] && !req[2'(i)] && ($urandom_range(99) < p_raise)) begin
        pd_dr[i]   = AW'($urandom);
        pd_data[i] = DW'($urandom);
        req[2'(i)] = 1'b1;
      end
    end
    drive_bus();
  endtask

  task automatic test_reset_and_init();
    do_reset('0, "init");
    step(0, 0, '0, "init_idle");
  endtask

  task automatic test_single();
    set_req(0, 3'd3, 16'hBEEF);
    step(0, 0, '0, "single_grant");
    step(0, 0, '0, "single_hold");
  endtask

  task automatic test_round_robin();
    do_reset('0, "rr");
    for (int i = 0; i < NREQ; i++) set_req(i, AW'($urandom), DW'($urandom));
    for (int c = 0; c < 9; c++) step(100, 0, '0, "rr_all_held");
  endtask

  task automatic test_single_held();
    do_reset('0, "held");
    set_req(0, 3'd1, 16'h1234);
    for (int c = 0; c < 6; c++) step(100, 0, '0, "held_alternate");
    req = '0;
    step(0, 0, '0, "held_drop");
  endtask

  task automatic test_req_at_release();
    pd_dr[1]   = 3'd6;
    pd_data[1] = 16'hA5A5;
    do_reset(3'b010, "early");
    step(0, 0, '0, "early_first_grant");
  endtask

  task automatic test_same_dr();
    do_reset('0, "same");
    set_req(0, 3'd5, 16'h0A0A);
    set_req(1, 3'd5, 16'hB0B0);
    for (int c = 0; c < 3; c++) step(0, 0, '0, "same_dr_order");
  endtask

  task automatic test_reset_mid_grant();
    do_reset('0, "midg");
    set_req(2, 3'd4, 16'hC3C3);
    step(100, 0, '0, "midg_grant");
    do_reset(req, "midg_rst");
    step(0, 0, '0, "midg_reserve");
  endtask

  task automatic test_reset_mid_sweep();
`ifdef REGFILE_ARB_CLEAR_EN
    logic [24:0] got;
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({ld_reg, dr} !== {1'b1, 3'd3}) begin
      n_err++;
      $display("FAIL midsweep_pre: got ld=%b dr=%0d want ld=1 dr=3", ld_reg, dr);
    end
    reset = 1'b1;
    #1;
    got = {gnt, ld_reg, dr, d_in, clear_done, busy};
    n_cmp++;
    if (got !== {3'b000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL midsweep_async_clear: got %h", got);
    end
    do_reset('0, "midsweep_restart");
    step(0, 0, '0, "midsweep_idle");
`endif
  endtask

  task automatic test_random();
    do_reset('0, "rand");
    for (int c = 0; c < 300; c++) step(60, 40, '1, "random");
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    for (int i = 0; i < NREQ; i++) begin
      pd_dr[i]   = '0;
      pd_data[i] = '0;
    end
    drive_bus();
    test_reset_and_init();
    test_single();
    test_round_robin();
    test_single_held();
    test_req_at_release();
    test_same_dr();
    test_reset_mid_grant();
    test_reset_mid_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
